// File: rtl/if_fetch_unit_if.sv
// Fetch-stage bus bundle: redirect/freeze controls, instruction-memory handshake, IF/ID outputs.
// master = fetch unit side, slave = environment (hazard unit, EXE, memory, IF/ID register).
// Widths follow ADDRESS_LEN / INSTRUCTION_LEN and must match the fetch unit instance.
interface if_fetch_unit_if #(
    parameter int ADDRESS_LEN     = 32,
    parameter int INSTRUCTION_LEN = 32
);
    // pipeline control
    logic                       freeze;
    logic                       branch_taken;
    logic [ADDRESS_LEN-1:0]     branch_address;
    // instruction memory
    logic                       imem_req;
    logic [ADDRESS_LEN-1:0]     imem_addr;
    logic                       imem_ack;
    logic                       imem_rvalid;
    logic [INSTRUCTION_LEN-1:0] imem_rdata;
    // towards IF/ID register
    logic                       if_valid;
    logic [ADDRESS_LEN-1:0]     if_pc;
    logic [INSTRUCTION_LEN-1:0] if_instruction;

    modport master (
        input  freeze, branch_taken, branch_address,
        input  imem_ack, imem_rvalid, imem_rdata,
        output imem_req, imem_addr,
        output if_valid, if_pc, if_instruction
    );

    modport slave (
        output freeze, branch_taken, branch_address,
        output imem_ack, imem_rvalid, imem_rdata,
        input  imem_req, imem_addr,
        input  if_valid, if_pc, if_instruction
    );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction fetch: owns the PC, one outstanding imem request, one-entry skid, branch redirect.
// Latency: output registered 1 cycle after imem_rvalid; 2 cycles/instr with a 1-cycle memory.
// Backpressure: freeze holds if_* bit-exact; one early response parks in the skid, then fetch stalls.
// Ports: clk, rst (async, active-low) plus the fetch bus (master modport):
//   freeze/branch_taken/branch_address in, imem_req/imem_addr out, imem_ack/imem_rvalid/imem_rdata in,
//   if_valid/if_pc/if_instruction out (if_pc = fetch address + PC_STEP).
module if_fetch_unit #(
    parameter int                     ADDRESS_LEN     = 32,
    parameter int                     INSTRUCTION_LEN = 32,
    parameter logic [ADDRESS_LEN-1:0] RESET_PC        = '0,
    parameter logic [ADDRESS_LEN-1:0] PC_STEP         = ADDRESS_LEN'(4)
) (
    input  logic            clk,
    input  logic            rst,
    if_fetch_unit_if.master fetch
);
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t                     r_state;
    logic [ADDRESS_LEN-1:0]     r_pc;
    logic [ADDRESS_LEN-1:0]     r_pc_req;
    logic                       r_kill;
    logic                       r_imem_req;
    logic [ADDRESS_LEN-1:0]     r_imem_addr;
    logic                       r_if_valid;
    logic [ADDRESS_LEN-1:0]     r_if_pc;
    logic [INSTRUCTION_LEN-1:0] r_if_instruction;
    logic                       r_skid_valid;
    logic [ADDRESS_LEN-1:0]     r_skid_pc;
    logic [INSTRUCTION_LEN-1:0] r_skid_instr;

    logic [ADDRESS_LEN-1:0]     w_pc_next;
    logic                       w_slot_free;

    // Wraps modulo 2^ADDRESS_LEN by construction.
    assign w_pc_next   = r_pc_req + PC_STEP;
    // The output register can take new data if it is empty or being consumed this edge.
    assign w_slot_free = !r_if_valid || !fetch.freeze;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state          <= S_REQ;
            r_pc             <= RESET_PC;
            r_pc_req         <= '0;
            r_kill           <= 1'b0;
            r_imem_req       <= 1'b0;
            r_imem_addr      <= '0;
            r_if_valid       <= 1'b0;
            r_if_pc          <= '0;
            r_if_instruction <= '0;
            r_skid_valid     <= 1'b0;
            r_skid_pc        <= '0;
            r_skid_instr     <= '0;
        end else begin
            // Consumption; overridden below when something replaces the output.
            if (r_if_valid && !fetch.freeze) begin
                r_if_valid <= 1'b0;
            end

            if (fetch.branch_taken) begin
                r_if_valid   <= 1'b0;
                r_skid_valid <= 1'b0;
                r_pc         <= fetch.branch_address;
                case (r_state)
                    S_REQ: begin
                        if (r_imem_req && fetch.imem_ack) begin
                            r_kill     <= 1'b1;
                            r_imem_req <= 1'b0;
                            r_state    <= S_WAIT;
                        end else if (r_imem_req) begin
                            // Request already on the bus must stay stable until acked:
                            // let it complete and throw its response away.
                            r_kill <= 1'b1;
                        end else begin
                            r_imem_req  <= 1'b1;
                            r_imem_addr <= fetch.branch_address;
                        end
                    end
                    S_WAIT: begin
                        if (fetch.imem_rvalid) begin
                            // Response lands this edge and is dropped: nothing left to kill.
                            r_kill      <= 1'b0;
                            r_state     <= S_REQ;
                            r_imem_req  <= 1'b1;
                            r_imem_addr <= fetch.branch_address;
                        end else begin
                            r_kill <= 1'b1;
                        end
                    end
                    default: begin
                        r_state     <= S_REQ;
                        r_imem_req  <= 1'b1;
                        r_imem_addr <= fetch.branch_address;
                    end
                endcase
            end else begin
                case (r_state)
                    S_REQ: begin
                        if (!r_imem_req) begin
                            // First cycle after reset: raise the request from the PC.
                            r_imem_req  <= 1'b1;
                            r_imem_addr <= r_pc;
                        end else if (fetch.imem_ack) begin
                            r_pc_req   <= r_pc;
                            r_imem_req <= 1'b0;
                            r_state    <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (fetch.imem_rvalid) begin
                            if (r_kill) begin
                                r_kill      <= 1'b0;
                                r_state     <= S_REQ;
                                r_imem_req  <= 1'b1;
                                r_imem_addr <= r_pc;
                            end else begin
                                r_pc <= w_pc_next;
                                if (w_slot_free) begin
                                    r_if_valid       <= 1'b1;
                                    r_if_pc          <= w_pc_next;
                                    r_if_instruction <= fetch.imem_rdata;
                                    r_state          <= S_REQ;
                                    r_imem_req       <= 1'b1;
                                    r_imem_addr      <= w_pc_next;
                                end else begin
                                    r_skid_valid <= 1'b1;
                                    r_skid_pc    <= w_pc_next;
                                    r_skid_instr <= fetch.imem_rdata;
                                    r_state      <= S_HOLD;
                                end
                            end
                        end
                    end
                    default: begin
                        // Skid drains into the output the edge the freeze lifts.
                        if (!fetch.freeze && r_skid_valid) begin
                            r_if_valid       <= 1'b1;
                            r_if_pc          <= r_skid_pc;
                            r_if_instruction <= r_skid_instr;
                            r_skid_valid     <= 1'b0;
                            r_state          <= S_REQ;
                            r_imem_req       <= 1'b1;
                            r_imem_addr      <= r_pc;
                        end
                    end
                endcase
            end
        end
    end

    assign fetch.imem_req       = r_imem_req;
    assign fetch.imem_addr      = r_imem_addr;
    assign fetch.if_valid       = r_if_valid;
    assign fetch.if_pc          = r_if_pc;
    assign fetch.if_instruction = r_if_instruction;
endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios, scoreboard of expected {if_pc, if_instruction}.
// Memory model returns word = address with programmable ack / rvalid delay and an ack budget.
// Inputs change at negedge+1, memory decides at negedge, monitor samples at negedge+4.
module tb_if_fetch_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    if_fetch_unit_if #(.ADDRESS_LEN(32), .INSTRUCTION_LEN(32)) bus ();

    if_fetch_unit #(
        .ADDRESS_LEN(32), .INSTRUCTION_LEN(32), .RESET_PC(32'h0), .PC_STEP(32'h4)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .fetch (bus)
    );

    int          n_chk = 0;
    int          n_err = 0;
    logic [63:0] sb_q[$];

    // memory model controls (driver) and state (memory process)
    logic        mem_flush     = 1'b1;
    int          mem_budget    = 0;
    int          mem_ack_delay = 0;
    int          mem_rv_delay  = 1;
    int          mem_acks      = 0;

    localparam int W_VALID    = 0;
    localparam int W_REQ_ADDR = 1;
    localparam int W_NOREQ    = 2;
    localparam int W_RVALID   = 3;
    localparam int W_EMPTY    = 4;
    localparam int W_REQ      = 5;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] ins);
        sb_q.push_back({pc, ins});
    endtask

    function automatic bit cond(input int what, input logic [31:0] val);
        case (what)
            W_VALID:    return bus.if_valid && (bus.if_pc == val);
            W_REQ_ADDR: return bus.imem_req && (bus.imem_addr == val);
            W_NOREQ:    return !bus.imem_req;
            W_RVALID:   return bus.imem_rvalid;
            W_EMPTY:    return sb_q.size() == 0;
            default:    return bus.imem_req;
        endcase
    endfunction

    task automatic wait_for(input int what, input logic [31:0] val, input string name);
        int n = 0;
        while (!cond(what, val) && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) begin
            n_chk++;
            n_err++;
            $display("FAIL %s: timed out after %0d cycles, required condition %0d val %h", name, n, what, val);
        end
    endtask

    task automatic do_reset(input int ack_d, input int rv_d, input int budget);
        rst              = 1'b0;
        mem_flush        = 1'b1;
        bus.freeze       = 1'b0;
        bus.branch_taken = 1'b0;
        mem_ack_delay    = ack_d;
        mem_rv_delay     = rv_d;
        mem_budget       = budget;
        tick();
        tick();
        mem_flush = 1'b0;
        rst       = 1'b1;
    endtask

    // instruction memory: one outstanding request, rdata = address
    initial begin
        logic        pending;
        logic [31:0] mem_addr;
        logic [31:0] ack_addr;
        int          ack_cnt;
        int          rv_cnt;
        pending = 1'b0; mem_addr = '0; ack_addr = '0; ack_cnt = 0; rv_cnt = 0;
        bus.imem_ack = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = '0;
        forever begin
            @(negedge clk);
            if (mem_flush) begin
                pending = 1'b0; ack_cnt = 0; rv_cnt = 0; mem_acks = 0;
            end else begin
                if (bus.imem_rvalid) pending = 1'b0;
                if (bus.imem_ack) begin
                    pending = 1'b1; mem_addr = ack_addr; rv_cnt = 1; ack_cnt = 0;
                    mem_acks++;
                end
            end
            bus.imem_ack    = 1'b0;
            bus.imem_rvalid = 1'b0;
            if (!mem_flush) begin
                if (pending) begin
                    if (rv_cnt >= mem_rv_delay) begin
                        bus.imem_rvalid = 1'b1;
                        bus.imem_rdata  = mem_addr;
                    end else begin
                        rv_cnt++;
                    end
                end else if (bus.imem_req && mem_acks < mem_budget) begin
                    if (ack_cnt >= mem_ack_delay) begin
                        bus.imem_ack = 1'b1;
                        ack_addr     = bus.imem_addr;
                    end else begin
                        ack_cnt++;
                    end
                end
            end
        end
    end

    // monitor: one pop per consumed output
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk);
            #4;
            if (rst && bus.if_valid && !bus.freeze && !bus.branch_taken) begin
                if (sb_q.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL sb_unexpected: got pc=%h instr=%h, required no output",
                             bus.if_pc, bus.if_instruction);
                end else begin
                    e = sb_q.pop_front();
                    check("sb_output", {bus.if_pc, bus.if_instruction}, e);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.freeze = 1'b0; bus.branch_taken = 1'b0; bus.branch_address = '0;
        #1 rst = 1'b0;
        #1;
        check("rst_if_valid",   64'(bus.if_valid),       64'h0);
        check("rst_if_pc",      64'(bus.if_pc),          64'h0);
        check("rst_if_instr",   64'(bus.if_instruction), 64'h0);
        check("rst_imem_req",   64'(bus.imem_req),       64'h0);
        check("rst_imem_addr",  64'(bus.imem_addr),      64'h0);

        // 1: sequential fetch, 1-cycle memory
        do_reset(0, 1, 3);
        push(32'd4, 32'd0); push(32'd8, 32'd4); push(32'd12, 32'd8);
        wait_for(W_VALID, 32'd4, "t1_first");
        for (int k = 0; k < 5; k++) begin
            check("t1_valid_pulse", 64'(bus.if_valid), 64'((k % 2) == 0));
            tick();
        end
        wait_for(W_EMPTY, 32'd0, "t1_drain");

        // 2: freeze with skid fill
        do_reset(0, 1, 4);
        push(32'd4, 32'd0); push(32'd8, 32'd4); push(32'd12, 32'd8); push(32'd16, 32'd12);
        wait_for(W_VALID, 32'd8, "t2_reach8");
        bus.freeze = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            check("t2_hold_pc",    64'(bus.if_pc),          64'd8);
            check("t2_hold_instr", 64'(bus.if_instruction), 64'd4);
            check("t2_hold_valid", 64'(bus.if_valid),       64'd1);
            check("t2_no_req",     64'(bus.imem_req),       64'd0);
        end
        bus.freeze = 1'b0;
        tick();
        check("t2_skid_pc",    64'(bus.if_pc),          64'd12);
        check("t2_skid_instr", 64'(bus.if_instruction), 64'd8);
        check("t2_resume_req", 64'(bus.imem_req),       64'd1);
        check("t2_resume_adr", 64'(bus.imem_addr),      64'd12);
        wait_for(W_EMPTY, 32'd0, "t2_drain");

        // 3: branch while waiting on 0x20
        do_reset(0, 3, 10);
        for (int k = 0; k < 8; k++) push(32'(4 * k + 4), 32'(4 * k));
        push(32'h104, 32'h100);
        wait_for(W_REQ_ADDR, 32'h20, "t3_req20");
        wait_for(W_NOREQ, 32'd0, "t3_wait20");
        bus.branch_taken = 1'b1; bus.branch_address = 32'h100;
        tick();
        bus.branch_taken = 1'b0;
        check("t3_valid_cleared", 64'(bus.if_valid), 64'd0);
        wait_for(W_REQ, 32'd0, "t3_req_target");
        check("t3_target_addr", 64'(bus.imem_addr), 64'h100);
        wait_for(W_EMPTY, 32'd0, "t3_drain");

        // 4: branch coincident with rvalid while frozen
        do_reset(0, 3, 4);
        push(32'd4, 32'd0); push(32'h204, 32'h200);
        wait_for(W_VALID, 32'd8, "t4_reach8");
        bus.freeze = 1'b1;
        wait_for(W_RVALID, 32'd0, "t4_rvalid");
        bus.branch_taken = 1'b1; bus.branch_address = 32'h200;
        tick();
        bus.branch_taken = 1'b0;
        check("t4_valid_killed", 64'(bus.if_valid),  64'd0);
        check("t4_req",          64'(bus.imem_req),  64'd1);
        check("t4_target_addr",  64'(bus.imem_addr), 64'h200);
        bus.freeze = 1'b0;
        wait_for(W_EMPTY, 32'd0, "t4_drain");

        // 5: ack withheld 5 cycles
        do_reset(5, 1, 2);
        push(32'd4, 32'd0); push(32'd8, 32'd4);
        wait_for(W_REQ, 32'd0, "t5_req");
        for (int k = 0; k < 5; k++) begin
            check("t5_req_held",    64'(bus.imem_req),  64'd1);
            check("t5_addr_stable", 64'(bus.imem_addr), 64'd0);
            tick();
        end
        wait_for(W_EMPTY, 32'd0, "t5_drain");
        check("t5_acks", 64'(mem_acks), 64'd2);

        // 6: PC wrap, then async reset mid-WAIT
        do_reset(0, 3, 3);
        bus.branch_taken = 1'b1; bus.branch_address = 32'hFFFF_FFFC;
        push(32'h0, 32'hFFFF_FFFC); push(32'h4, 32'h0);
        tick();
        bus.branch_taken = 1'b0;
        check("t6_req_top", 64'(bus.imem_addr), 64'hFFFF_FFFC);
        wait_for(W_VALID, 32'h0, "t6_wrap");
        check("t6_wrap_instr", 64'(bus.if_instruction), 64'hFFFF_FFFC);
        check("t6_next_req",   64'(bus.imem_req),       64'd1);
        check("t6_next_addr",  64'(bus.imem_addr),      64'h0);
        wait_for(W_REQ_ADDR, 32'h4, "t6_req4");
        wait_for(W_NOREQ, 32'd0, "t6_wait4");
        rst = 1'b0;
        #1;
        check("t6_arst_valid", 64'(bus.if_valid),       64'h0);
        check("t6_arst_pc",    64'(bus.if_pc),          64'h0);
        check("t6_arst_instr", 64'(bus.if_instruction), 64'h0);
        check("t6_arst_req",   64'(bus.imem_req),       64'h0);
        check("t6_arst_addr",  64'(bus.imem_addr),      64'h0);
        tick();
        tick();
        rst = 1'b1;
        repeat (8) tick();
        check("t6_stale_valid", 64'(bus.if_valid),  64'h0);
        check("t6_refetch_req", 64'(bus.imem_req),  64'h1);
        check("t6_refetch_adr", 64'(bus.imem_addr), 64'h0);
        check("sb_final_empty", 64'(sb_q.size()),   64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
